// File: rtl/tapped_delay_line.sv
// Sample-enabled delay line with selectable output tap, full tap bus and fill tracking.
// Stages shift only on accepted samples; flush clears the line and the fill count.
module tapped_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    input  logic [WIDTH-1:0]                             data_in,
    input  logic                                         flush,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] tap_sel,
    output logic [WIDTH-1:0]                             data_out,
    output logic                                         tap_valid,
    output logic [DEPTH*WIDTH-1:0]                       taps,
    output logic                                         out_stb,
    output logic                                         full,
    output logic [$clog2(DEPTH+1)-1:0]                   fill_cnt
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage_reg [DEPTH];
    logic [CNT_W-1:0] fill_cnt_reg;
    logic             out_stb_reg;
    logic [31:0]      sel_ext;
    logic [31:0]      cnt_ext;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg[gi] <= '0;
                end else if (flush) begin
                    stage_reg[gi] <= '0;
                end else if (in_valid) begin
                    if (gi == 0) begin
                        stage_reg[gi] <= data_in;
                    end else begin
                        stage_reg[gi] <= stage_reg[(gi > 0) ? gi - 1 : 0];
                    end
                end
            end
            assign taps[gi*WIDTH +: WIDTH] = stage_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_reg <= '0;
            out_stb_reg  <= 1'b0;
        end else if (flush) begin
            fill_cnt_reg <= '0;
            out_stb_reg  <= 1'b0;
        end else if (in_valid) begin
            if (fill_cnt_reg != CNT_MAX) begin
                fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
            out_stb_reg <= 1'b1;
        end else begin
            out_stb_reg <= 1'b0;
        end
    end

    assign sel_ext = 32'(tap_sel);
    assign cnt_ext = 32'(fill_cnt_reg);

    // Out-of-range selects (non-power-of-two DEPTH) fall through to zero.
    always_comb begin
        data_out = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel_ext == 32'(k)) begin
                data_out = stage_reg[k];
            end
        end
    end

    assign tap_valid = (sel_ext < 32'(DEPTH)) && (cnt_ext > sel_ext);
    assign full      = (fill_cnt_reg == CNT_MAX);
    assign fill_cnt  = fill_cnt_reg;
    assign out_stb   = out_stb_reg;

    logic unused_sel_w;
    assign unused_sel_w = (SEL_W > 0);
endmodule
